// File: rtl/cpu_types_pkg.sv
// Shared CPU tile types: word type and instruction cache fill FSM state.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} icache_assoc_state_t;
endpackage

// File: rtl/icache_victim_sel.sv
// Victim way for one set: lowest-index invalid way, else the set's round-robin pointer.
module icache_victim_sel #(
  parameter int NWAYS = 2,
  parameter int WAYW  = 1
) (
  input  logic [NWAYS-1:0] valid,
  input  logic [WAYW-1:0]  ptr,
  output logic [WAYW-1:0]  way,
  output logic             from_ptr
);
  // Scan high to low so the lowest invalid way is the last one written.
  always_comb begin
    way      = ptr;
    from_ptr = 1'b1;
    for (int w = NWAYS-1; w >= 0; w--) begin
      if (!valid[w]) begin
        way      = WAYW'(w);
        from_ptr = 1'b0;
      end
    end
  end
endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache, same-cycle hits, word-by-word block fill.
// Define ICACHE_STATS_EN to build the saturating hit/miss counters.
module icache_assoc
  import cpu_types_pkg::*;
#(
  parameter int CPUID = 0,
  parameter int NSETS = 8,
  parameter int NWAYS = 2,
  parameter int WPB   = 2
) (
  input  logic  clk,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  input  logic  iflush,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);
  localparam int BOB  = $clog2(WPB);
  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 30 - BOB - IDXW;
  localparam int WAYW = (NWAYS > 1) ? $clog2(NWAYS) : 1;
  localparam int KW   = (WPB > 1) ? BOB : 1;

  if (CPUID < 0 || NSETS < 2 || (NSETS & (NSETS-1)) != 0 || NWAYS < 1 ||
      (NWAYS & (NWAYS-1)) != 0 || WPB < 1 || (WPB & (WPB-1)) != 0) begin : g_bad_param
    $error("icache_assoc: illegal parameters");
  end

  icache_assoc_state_t state;
  logic [NSETS-1:0][NWAYS-1:0] valid;
  logic [NSETS-1:0][WAYW-1:0]  rr_ptr;
  logic [TAGW-1:0] tags [NSETS][NWAYS];
  word_t           data [NSETS][NWAYS][WPB];

  logic [TAGW-1:0]  req_tag, fill_tag;
  logic [IDXW-1:0]  req_idx, fill_idx;
  logic [KW-1:0]    req_off, k;
  logic [WAYW-1:0]  vic_way, fill_way;
  logic             vic_from_ptr, fill_from_ptr;
  logic [NWAYS-1:0] match;
  word_t            hit_word;
  logic             lookup_hit, miss_start, word_done, fill_done;

  // Shift/mask split keeps WPB=1 (no block offset bits) legal.
  assign req_tag = TAGW'(imemaddr >> (2 + BOB + IDXW));
  assign req_idx = IDXW'(imemaddr >> (2 + BOB));
  assign req_off = KW'((imemaddr >> 2) & word_t'(WPB - 1));

  for (genvar w = 0; w < NWAYS; w++) begin : g_way
    assign match[w] = valid[req_idx][w] && (tags[req_idx][w] == req_tag);
  end

  always_comb begin
    hit_word = '0;
    for (int w = 0; w < NWAYS; w++)
      if (match[w]) hit_word = hit_word | data[req_idx][w][req_off];
  end

  assign lookup_hit = |match;
  assign ihit       = (state == IDLE) && imemREN && lookup_hit && !iflush;
  assign imemload   = (state == IDLE && lookup_hit) ? hit_word : '0;
  assign iREN       = (state == FILL);
  assign miss_start = (state == IDLE) && imemREN && !lookup_hit && !iflush;
  assign word_done  = (state == FILL) && !iwait && !iflush;
  assign fill_done  = word_done && (k == KW'(WPB - 1));

  icache_victim_sel #(.NWAYS(NWAYS), .WAYW(WAYW)) u_victim (
    .valid    (valid[req_idx]),
    .ptr      (rr_ptr[req_idx]),
    .way      (vic_way),
    .from_ptr (vic_from_ptr)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      valid         <= '0;
      rr_ptr        <= '0;
      iaddr         <= '0;
      k             <= '0;
      fill_tag      <= '0;
      fill_idx      <= '0;
      fill_way      <= '0;
      fill_from_ptr <= 1'b0;
    end else if (iflush) begin
      state  <= IDLE;
      valid  <= '0;
      rr_ptr <= '0;
    end else if (miss_start) begin
      state         <= FILL;
      fill_tag      <= req_tag;
      fill_idx      <= req_idx;
      fill_way      <= vic_way;
      fill_from_ptr <= vic_from_ptr;
      k             <= '0;
      iaddr         <= imemaddr & ~word_t'(4*WPB - 1);
    end else if (word_done) begin
      if (fill_done) begin
        state                     <= IDLE;
        valid[fill_idx][fill_way] <= 1'b1;
        // Only a pointer-chosen victim rotates; filling an empty way leaves it.
        if (fill_from_ptr)
          rr_ptr[fill_idx] <= (rr_ptr[fill_idx] == WAYW'(NWAYS-1)) ? '0 : rr_ptr[fill_idx] + 1'b1;
      end else begin
        k     <= k + 1'b1;
        iaddr <= iaddr + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_done) begin
      data[fill_idx][fill_way][k] <= iload;
      if (fill_done) tags[fill_idx][fill_way] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && hit_count != '1)        hit_count  <= hit_count + 32'd1;
      if (miss_start && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: directed cases with literal expectations, then random traffic
// checked every cycle against a set/way reference model.
`timescale 1ns/1ps
module tb_icache_assoc;
  localparam int NSETS = 8, NWAYS = 2, WPB = 2;
  localparam int BLKB  = 4*WPB;

  logic        clk, nRST, imemREN, iflush, ihit, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload, hit_count, miss_count;

  icache_assoc #(.CPUID(0), .NSETS(NSETS), .NWAYS(NWAYS), .WPB(WPB)) dut (
    .clk(clk), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
    .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_cmp = 0, n_fail = 0;
  int lat_cfg = 2;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memval(input logic [31:0] a);
    return 32'hAAAA0000 + a - 32'h40;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: per-word latency (fixed or random 0..3 wait cycles), then one iwait=0 cycle.
  initial begin
    int  rem;
    bit  busy;
    busy = 0; rem = 0; iwait = 1; iload = '0;
    forever begin
      @(posedge clk); #1;
      if (!iREN) begin
        busy = 0; iwait = 1;
      end else begin
        if (!busy) begin
          busy = 1;
          rem  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        end
        if (rem == 0) begin
          iwait = 0; iload = memval(iaddr); busy = 0;
        end else begin
          iwait = 1; rem--;
        end
      end
    end
  end

  // Reference model: per-set line arrays plus one pending block fill.
  bit          m_valid [NSETS][NWAYS];
  int unsigned m_tag   [NSETS][NWAYS];
  logic [31:0] m_data  [NSETS][NWAYS][WPB];
  int          m_ptr   [NSETS];
  bit          m_fill, m_fromptr;
  int          m_way, m_k;
  logic [31:0] m_base, m_last, m_hits, m_misses;

  task automatic model_clear(input bit full);
    for (int s = 0; s < NSETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 0;
    end
    m_fill = 0;
    if (full) begin m_last = 0; m_hits = 0; m_misses = 0; end
  endtask

  initial begin
    int unsigned a, s, t, o;
    int fw;
    bit exp_hit;
    model_clear(1);
    forever begin
      @(negedge clk);
      if (!nRST) begin
        check("rst_ihit", ihit, 0);
        check("rst_iREN", iREN, 0);
        check("rst_iaddr", iaddr, 0);
        check("rst_imemload", imemload, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        model_clear(1);
      end else begin
        a = imemaddr;
        s = (a / BLKB) % NSETS;
        t = a / (BLKB*NSETS);
        o = (a / 4) % WPB;
        fw = -1;
        for (int w = 0; w < NWAYS; w++)
          if (m_valid[s][w] && m_tag[s][w] == t) fw = w;
        exp_hit = 0;
        if (m_fill) begin
          check("fill_ihit", ihit, 0);
          check("fill_iREN", iREN, 1);
          check("fill_iaddr", iaddr, m_base + 32'(4*m_k));
        end else begin
          exp_hit = imemREN && fw >= 0 && !iflush;
          check("idle_ihit", ihit, exp_hit);
          check("idle_iREN", iREN, 0);
          check("idle_iaddr", iaddr, m_last);
          check("idle_imemload", imemload, (fw >= 0) ? m_data[s][fw][o] : 32'h0);
        end
`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
`else
        check("hit_count_off", hit_count, 0);
        check("miss_count_off", miss_count, 0);
`endif
        if (exp_hit && m_hits != 32'hFFFF_FFFF) m_hits++;
        if (iflush) begin
          model_clear(0);
        end else if (!m_fill) begin
          if (imemREN && fw < 0) begin
            m_base = a & ~32'(BLKB-1);
            m_last = m_base;
            m_k = 0;
            m_way = -1;
            for (int w = 0; w < NWAYS; w++) if (!m_valid[s][w] && m_way < 0) m_way = w;
            m_fromptr = (m_way < 0);
            if (m_way < 0) m_way = m_ptr[s];
            m_fill = 1;
            if (m_misses != 32'hFFFF_FFFF) m_misses++;
          end
        end else if (!iwait) begin
          s = (m_base / BLKB) % NSETS;
          m_data[s][m_way][m_k] = memval(m_base + 32'(4*m_k));
          if (m_k == WPB-1) begin
            m_valid[s][m_way] = 1;
            m_tag[s][m_way] = m_base / (BLKB*NSETS);
            if (m_fromptr) m_ptr[s] = (m_ptr[s] + 1) % NWAYS;
            m_fill = 0;
          end else begin
            m_k++;
            m_last = m_base + 32'(4*m_k);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic read(input logic [31:0] a, input bit exp_hit, input string nm);
    int n;
    imemREN = 1; imemaddr = a;
    @(negedge clk);
    check({nm, "_first_ihit"}, ihit, exp_hit);
    if (!exp_hit) begin
      tick(); @(negedge clk);
      check({nm, "_iREN"}, iREN, 1);
      check({nm, "_iaddr"}, iaddr, a & ~32'(BLKB-1));
      n = 0;
      while (!ihit && n < 200) begin tick(); @(negedge clk); n++; end
      check({nm, "_done"}, ihit, 1);
    end
    check({nm, "_data"}, imemload, memval(a & ~32'h3));
    tick(); imemREN = 0;
  endtask

  initial begin
    int n;
    logic [31:0] first, last;
    nRST = 1; imemREN = 0; iflush = 0; imemaddr = '0;
    #2 nRST = 0;
    repeat (2) tick();
    nRST = 1;
    @(negedge clk);
    check("reset_ihit", ihit, 0);
    check("reset_iREN", iREN, 0);
    check("reset_iaddr", iaddr, 0);
    check("reset_imemload", imemload, 0);
    tick();

    // Cold miss, 2 wait cycles per word: 1 + 3 + 3 cycles to the hit.
    lat_cfg = 2;
    imemREN = 1; imemaddr = 32'h40;
    @(negedge clk);
    check("t1_miss_ihit", ihit, 0);
    n = 0; first = 0; last = 0;
    do begin
      tick(); @(negedge clk); n++;
      if (iREN) begin
        if (first == 0) first = iaddr;
        last = iaddr;
      end
    end while (!ihit && n < 50);
    check("t1_latency", n, 7);
    check("t1_first_iaddr", first, 32'h40);
    check("t1_last_iaddr", last, 32'h44);
    check("t1_data40", imemload, 32'hAAAA0000);
    tick(); imemaddr = 32'h44;
    @(negedge clk);
    check("t1_hit44", ihit, 1);
    check("t1_data44", imemload, 32'hAAAA0004);
    check("t1_iREN_idle", iREN, 0);
    tick(); imemREN = 0;
    @(negedge clk);
`ifdef ICACHE_STATS_EN
    check("t6_miss_count", miss_count, 1);
    check("t6_hit_count", hit_count, 2);
`else
    check("t6_miss_count_off", miss_count, 0);
    check("t6_hit_count_off", hit_count, 0);
`endif
    tick();

    // Conflicts in set 0: empty way first, then round-robin eviction.
    read(32'h80, 0, "t2_fill80");
    read(32'hC0, 0, "t2_fillC0");
    read(32'h80, 1, "t2_hit80");
    read(32'h40, 0, "t2_miss40");
    read(32'hC0, 1, "t2_hitC0");
    read(32'h80, 0, "t2_miss80");
    read(32'h40, 1, "t2_hit40");

    // Flush in IDLE, then flush mid-fill.
    iflush = 1; tick(); iflush = 0;
    read(32'h40, 0, "t3_after_flush");
    imemREN = 1; imemaddr = 32'h48;
    tick(); tick();
    iflush = 1; imemREN = 0; tick(); iflush = 0;
    @(negedge clk);
    check("t3_abort_iREN", iREN, 0);
    tick();
    read(32'h48, 0, "t3_refill48");

    // Fill continues after imemREN drops and the address moves.
    iflush = 1; tick(); iflush = 0;
    imemREN = 1; imemaddr = 32'h40;
    tick();
    imemREN = 0;
    n = 0;
    do begin imemaddr = $urandom; tick(); @(negedge clk); n++; end while (iREN && n < 50);
    check("t4_fill_ended", iREN, 0);
    check("t4_iaddr_hold", iaddr, 32'h44);
    tick();
    read(32'h44, 1, "t4_hit44");

    // Reset mid-fill: iREN falls immediately, lines gone afterwards.
    imemREN = 1; imemaddr = 32'h100;
    tick(); tick();
    nRST = 0; #1;
    check("t5_iREN_async", iREN, 0);
    imemREN = 0;
    tick(); tick();
    nRST = 1;
    read(32'h40, 0, "t5_after_reset");

    // Random traffic over 16 blocks in 4 sets (8 lines) with random latency.
    lat_cfg = -1;
    for (int i = 0; i < 4000; i++) begin
      imemREN  = ($urandom_range(0, 3) != 0);
      imemaddr = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 3) |
                 ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      iflush   = ($urandom_range(0, 59) == 0);
      if (i == 2000) nRST = 0;
      if (i == 2002) nRST = 1;
      tick();
    end
    imemREN = 0; iflush = 0; nRST = 1;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
